// File: rtl/pkt_cutter_mc.sv
// pkt_cutter_mc: truncates each AXI-Stream packet to a per-source-port snap
// length, masks the strobes of the last kept beat and swallows the rest.
// Optional feature macro: PKT_CUTTER_LEN_UPDATE_EN rewrites tuser[15:0] of the
// first output beat to min(original length, cut length) when a cut is active.
module pkt_cutter_mc #(
  parameter int          DATA_WIDTH   = 256,
  parameter int          TUSER_WIDTH  = 128,
  parameter int          NUM_PORTS    = 8,
  parameter int          SRC_PORT_LSB = 16,
  parameter logic [15:0] DEFAULT_CUT  = 16'd0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_wr_en,
  input  logic [7:0]                cfg_addr,
  input  logic [15:0]               cfg_wdata,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic [TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic [TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready
);

  localparam int          DATA_BYTES = DATA_WIDTH / 8;
  localparam int          PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [16:0] BEAT_BYTES = 17'(DATA_BYTES);

  typedef enum logic [1:0] {
    ST_FIRST,
    ST_PASS,
    ST_DROP
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    enable;
  logic [15:0]             cut_len_tbl [NUM_PORTS];
  logic [15:0]             cut_len_q;
  logic [15:0]             cut_len_cur;
  logic [15:0]             byte_cnt;
  logic [PORT_W-1:0]       port_idx;
  logic [16:0]             beat_end;
  logic [16:0]             keep_bytes;
  logic                    accept;
  logic                    load;
  logic                    cut_hit;
  logic                    cut_beat;
  logic [DATA_BYTES-1:0]   lane_mask;
  logic [TUSER_WIDTH-1:0]  user_out;

  // Dropped beats are always taken; otherwise accept only when the output slot frees up.
  assign s_axis_tready = (state == ST_DROP) | ~m_axis_tvalid | m_axis_tready;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign load          = accept & (state != ST_DROP);

  // Lowest set bit of the one-hot source-port field picks the table entry (entry 0 if none).
  always_comb begin
    port_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (s_axis_tuser[SRC_PORT_LSB + i]) begin
        port_idx = PORT_W'(i);
      end
    end
  end

  // The cut length is sampled from the table on the first beat and held for the rest of the packet.
  always_comb begin
    cut_len_cur = cut_len_q;
    if (state == ST_FIRST) begin
      cut_len_cur = enable ? cut_len_tbl[port_idx] : 16'd0;
    end
    beat_end   = {1'b0, byte_cnt} + BEAT_BYTES;
    keep_bytes = {1'b0, cut_len_cur} - {1'b0, byte_cnt};
    cut_hit    = (cut_len_cur != 16'd0) && ({1'b0, cut_len_cur} <= beat_end);
    cut_beat   = cut_hit & ~s_axis_tlast;
  end

  // Strobe mask keeps lanes below the cut point on the beat where the cut lands.
  always_comb begin
    lane_mask = '1;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (cut_hit) begin
        lane_mask[i] = (17'(i) < keep_bytes);
      end
    end
  end

  // Sideband passes through; optionally the first beat's length field reflects the cut.
  always_comb begin
    user_out = s_axis_tuser;
`ifdef PKT_CUTTER_LEN_UPDATE_EN
    if ((state == ST_FIRST) && (cut_len_cur != 16'd0) && (cut_len_cur < s_axis_tuser[15:0])) begin
      user_out[15:0] = cut_len_cur;
    end
`endif
  end

  // Packet framing: forward until the end or the cut beat, then swallow to tlast.
  always_comb begin
    state_next = state;
    if (accept) begin
      case (state)
        ST_FIRST, ST_PASS: begin
          if (s_axis_tlast) begin
            state_next = ST_FIRST;
          end else if (cut_hit) begin
            state_next = ST_DROP;
          end else begin
            state_next = ST_PASS;
          end
        end
        ST_DROP: begin
          if (s_axis_tlast) begin
            state_next = ST_FIRST;
          end
        end
        default: state_next = ST_FIRST;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FIRST;
    end else begin
      state <= state_next;
    end
  end

  // Byte offset of the current beat within its packet, saturating, cleared at packet end.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt  <= 16'd0;
      cut_len_q <= 16'd0;
    end else if (accept) begin
      if (state == ST_FIRST) begin
        cut_len_q <= cut_len_cur;
      end
      if (s_axis_tlast) begin
        byte_cnt <= 16'd0;
      end else if (beat_end[16]) begin
        byte_cnt <= 16'hFFFF;
      end else begin
        byte_cnt <= beat_end[15:0];
      end
    end
  end

  // Configuration registers; out-of-range addresses fall through untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        cut_len_tbl[i] <= DEFAULT_CUT;
      end
    end else if (cfg_wr_en) begin
      if (cfg_addr == 8'd0) begin
        enable <= cfg_wdata[0];
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (cfg_addr == 8'(i + 1)) begin
          cut_len_tbl[i] <= cfg_wdata;
        end
      end
    end
  end

  // Single output register stage that holds under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tuser  <= '0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= s_axis_tlast | cut_beat;
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tstrb  <= s_axis_tstrb & lane_mask;
      m_axis_tuser  <= user_out;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule
